tft_powerdown_seq: RTL and testbench
====================================

TFT_POWERDOWN_SEQ -- requirements
Module: tft_powerdown_seq

Interface
REQ-001 Parameter STEP_DLY, default 16'd1000, meaning cycles of clk_out between consecutive power-down steps (legal 1..65535; 0 SHALL behave as 1).
REQ-002 Parameter FRAME_TO, default 16'd50000, meaning max cycles to wait for a frame boundary before forcing the first step (legal 1..65535; 0 SHALL behave as 1).
REQ-003 clk_out  input  1  system/pixel clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high; clock clk_out.
REQ-005 pd_req  input  1  power-down request; sampled high starts the sequence.
REQ-006 frame_end  input  1  one-cycle pulse from the timing generator at end of the last active line.
REQ-007 busy  output  1  high while the sequence is in progress.
REQ-008 pd_done  output  1  high once all enables are off; held until reset.
REQ-009 TFT_en, de_en, disp_en, led_en, rgb_en, pixel_en, en_sync  output  1 each  panel enables, registered; downstream ANDs each with the matching power-up sequencer output.

Function
REQ-010 States SHALL be ON, WAIT_FRAME, LED_OFF, DISP_OFF, DATA_OFF, TFT_OFF, DONE; encoding free, unused codes SHALL go to DONE with all enables 0.
REQ-011 ON: all seven enables 1, busy 0, pd_done 0; pd_req=1 -> WAIT_FRAME at that edge, busy 1 from the same edge.
REQ-012 WAIT_FRAME: frame_end=1, or wait counter reaching FRAME_TO cycles -> LED_OFF; led_en 0 at that edge.
REQ-013 frame_end in the same cycle pd_req is first sampled in ON SHALL be ignored; only pulses seen in WAIT_FRAME count.
REQ-014 LED_OFF: after STEP_DLY cycles in state -> DISP_OFF, disp_en 0 at that edge.
REQ-015 DISP_OFF: after STEP_DLY cycles -> DATA_OFF, de_en, rgb_en, pixel_en, en_sync all 0 at the same edge.
REQ-016 DATA_OFF: after STEP_DLY cycles -> TFT_OFF, TFT_en 0 at that edge.
REQ-017 TFT_OFF: after STEP_DLY cycles -> DONE, pd_done 1, busy 0 at that edge.
REQ-018 DONE: all enables 0, pd_done 1, busy 0; leaves only on rst.
REQ-019 One 16-bit down/up counter SHALL time all waits; cleared on every state entry; "N cycles in state" means transition on the edge that ends the Nth cycle after entry.
REQ-020 Deassertion of pd_req after the sequence starts SHALL be ignored; the sequence always completes.
REQ-021 frame_end outside WAIT_FRAME SHALL have no effect.
REQ-022 Enables SHALL only ever change 1->0 outside reset; never glitch or re-assert mid-sequence.
REQ-023 Disable order SHALL be fixed: led_en, disp_en, {de_en,rgb_en,pixel_en,en_sync}, TFT_en.

Reset
REQ-024 rst=1 at a clock edge SHALL force state ON, counter 0, all enables 1, busy 0, pd_done 0, overriding any other input that cycle.
REQ-025 rst during any sequence state (including DONE) SHALL abort and return to ON on that edge.
REQ-026 No initial blocks for functional state; behaviour before first rst is undefined.

Verification (STEP_DLY=4, FRAME_TO=16 unless stated)
REQ-027 rst 2 cycles, pd_req low 20 cycles -> all enables 1, busy 0, pd_done 0 throughout.
REQ-028 pd_req pulse at edge t0, frame_end at t0+3 -> led_en 0 at t0+3, disp_en 0 at t0+7, de/rgb/pixel/en_sync 0 at t0+11, TFT_en 0 at t0+15, pd_done 1 and busy 0 at t0+19.
REQ-029 pd_req at t0, no frame_end -> led_en 0 at t0+16 (timeout), remaining steps at +4 spacing, pd_done at t0+32.
REQ-030 rst asserted at the edge disp_en would drop (mid-sequence) -> all enables 1, busy 0 next cycle; new pd_req restarts from WAIT_FRAME.
REQ-031 pd_req and frame_end both high in ON, pd_req dropped next cycle, frame_end pulsed at t0+5 -> led_en drops at t0+5, not t0; sequence completes.
REQ-032 STEP_DLY=0, FRAME_TO=0 -> each step occurs 1 cycle after the previous; pd_done at t0+5.

Source files
------------

// File: rtl/tft_powerdown_seq.sv
// TFT panel power-down sequencer: waits for a frame boundary (or timeout), then
// drops the panel enables one group at a time, STEP_DLY cycles apart.
module tft_powerdown_seq #(
    parameter logic [15:0] STEP_DLY = 16'd1000,
    parameter logic [15:0] FRAME_TO = 16'd50000
) (
    input  logic clk_out,
    input  logic rst,
    input  logic pd_req,
    input  logic frame_end,
    output logic busy,
    output logic pd_done,
    output logic TFT_en,
    output logic de_en,
    output logic disp_en,
    output logic led_en,
    output logic rgb_en,
    output logic pixel_en,
    output logic en_sync
);

    typedef enum logic [2:0] {
        ST_ON         = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_LED_OFF    = 3'd2,
        ST_DISP_OFF   = 3'd3,
        ST_DATA_OFF   = 3'd4,
        ST_TFT_OFF    = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    // A zero delay is treated as one cycle, so the terminal count is 0 in both cases.
    localparam logic [15:0] STEP_LAST  = (STEP_DLY == 16'd0) ? 16'd0 : STEP_DLY - 16'd1;
    localparam logic [15:0] FRAME_LAST = (FRAME_TO == 16'd0) ? 16'd0 : FRAME_TO - 16'd1;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_busy;
    logic        r_pd_done;
    logic        r_led_en;
    logic        r_disp_en;
    logic        r_data_en;
    logic        r_tft_en;

    logic w_step_hit;
    logic w_frame_hit;

    assign w_step_hit  = (r_cnt == STEP_LAST);
    assign w_frame_hit = (r_cnt == FRAME_LAST);

    always_ff @(posedge clk_out) begin
        if (rst) begin
            r_state   <= ST_ON;
            r_cnt     <= 16'd0;
            r_busy    <= 1'b0;
            r_pd_done <= 1'b0;
            r_led_en  <= 1'b1;
            r_disp_en <= 1'b1;
            r_data_en <= 1'b1;
            r_tft_en  <= 1'b1;
        end else begin
            case (r_state)
                ST_ON: begin
                    r_cnt <= 16'd0;
                    if (pd_req) begin
                        r_state <= ST_WAIT_FRAME;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_FRAME: begin
                    // frame_end only counts from the first cycle after the request.
                    if (frame_end || w_frame_hit) begin
                        r_state  <= ST_LED_OFF;
                        r_led_en <= 1'b0;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_LED_OFF: begin
                    if (w_step_hit) begin
                        r_state   <= ST_DISP_OFF;
                        r_disp_en <= 1'b0;
                        r_cnt     <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DISP_OFF: begin
                    if (w_step_hit) begin
                        r_state   <= ST_DATA_OFF;
                        r_data_en <= 1'b0;
                        r_cnt     <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DATA_OFF: begin
                    if (w_step_hit) begin
                        r_state  <= ST_TFT_OFF;
                        r_tft_en <= 1'b0;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_TFT_OFF: begin
                    if (w_step_hit) begin
                        r_state   <= ST_DONE;
                        r_pd_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_cnt     <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_cnt     <= 16'd0;
                    r_busy    <= 1'b0;
                    r_pd_done <= 1'b1;
                    r_led_en  <= 1'b0;
                    r_disp_en <= 1'b0;
                    r_data_en <= 1'b0;
                    r_tft_en  <= 1'b0;
                end
                default: begin
                    // Illegal code: park safely with the panel fully off.
                    r_state   <= ST_DONE;
                    r_cnt     <= 16'd0;
                    r_busy    <= 1'b0;
                    r_pd_done <= 1'b1;
                    r_led_en  <= 1'b0;
                    r_disp_en <= 1'b0;
                    r_data_en <= 1'b0;
                    r_tft_en  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign pd_done  = r_pd_done;
    assign led_en   = r_led_en;
    assign disp_en  = r_disp_en;
    assign de_en    = r_data_en;
    assign rgb_en   = r_data_en;
    assign pixel_en = r_data_en;
    assign en_sync  = r_data_en;
    assign TFT_en   = r_tft_en;

endmodule

// File: tb/tb_tft_powerdown_seq.sv
// Scoreboard bench for tft_powerdown_seq: two instances (4/16 and 0/0 delays)
// share one randomized input stream and are checked against a timeline model.
module tb_tft_powerdown_seq;

    logic clk_out = 1'b0;
    logic rst = 1'b0;
    logic pd_req = 1'b0;
    logic frame_end = 1'b0;

    logic busy_a, pd_done_a, tft_a, de_a, disp_a, led_a, rgb_a, pix_a, sync_a;
    logic busy_b, pd_done_b, tft_b, de_b, disp_b, led_b, rgb_b, pix_b, sync_b;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    // Per-instance model: milestone cycles only (request edge, LED-off edge).
    int  m_step [2];
    int  m_fto  [2];
    bit  m_started [2];
    int  m_t0   [2];
    int  m_tled [2];

    logic [8:0] q_exp [2][$];

    always #5 clk_out = ~clk_out;

    tft_powerdown_seq #(.STEP_DLY(16'd4), .FRAME_TO(16'd16)) dut_a (
        .clk_out(clk_out), .rst(rst), .pd_req(pd_req), .frame_end(frame_end),
        .busy(busy_a), .pd_done(pd_done_a), .TFT_en(tft_a), .de_en(de_a),
        .disp_en(disp_a), .led_en(led_a), .rgb_en(rgb_a), .pixel_en(pix_a),
        .en_sync(sync_a)
    );

    tft_powerdown_seq #(.STEP_DLY(16'd0), .FRAME_TO(16'd0)) dut_b (
        .clk_out(clk_out), .rst(rst), .pd_req(pd_req), .frame_end(frame_end),
        .busy(busy_b), .pd_done(pd_done_b), .TFT_en(tft_b), .de_en(de_b),
        .disp_en(disp_b), .led_en(led_b), .rgb_en(rgb_b), .pixel_en(pix_b),
        .en_sync(sync_b)
    );

    // Expected outputs after the edge at cycle n, vector order:
    // {TFT_en, de_en, disp_en, led_en, rgb_en, pixel_en, en_sync, busy, pd_done}
    task automatic model_step(input int k, input int n, input bit r, input bit p,
                              input bit f, output logic [8:0] exp_v);
        int  d;
        int  s;
        bit  data_on;
        bit  done;
        s = m_step[k];
        if (r) begin
            m_started[k] = 1'b0;
        end else if (!m_started[k]) begin
            if (p) begin
                m_started[k] = 1'b1;
                m_t0[k] = n;
                m_tled[k] = -1;
                if (k == 0) $display("transaction: power-down request at cycle %0d", n);
            end
        end else if (m_tled[k] < 0) begin
            if (f || (n - m_t0[k] == m_fto[k])) m_tled[k] = n;
        end
        if (!m_started[k]) begin
            exp_v = 9'b1111111_0_0;
        end else if (m_tled[k] < 0) begin
            exp_v = 9'b1111111_1_0;
        end else begin
            d = n - m_tled[k];
            data_on = (d < 2 * s);
            done = (d >= 4 * s);
            exp_v = {(d < 3 * s), data_on, (d < s), 1'b0, data_on, data_on, data_on,
                     !done, done};
        end
    endtask

    task automatic drive(input bit r, input bit p, input bit f);
        logic [8:0] e;
        @(negedge clk_out);
        rst = r;
        pd_req = p;
        frame_end = f;
        cycle++;
        for (int k = 0; k < 2; k++) begin
            model_step(k, cycle, r, p, f, e);
            q_exp[k].push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle once driven; compare after each edge.
    always @(posedge clk_out) begin
        logic [8:0] act [2];
        logic [8:0] e;
        #1;
        act[0] = {tft_a, de_a, disp_a, led_a, rgb_a, pix_a, sync_a, busy_a, pd_done_a};
        act[1] = {tft_b, de_b, disp_b, led_b, rgb_b, pix_b, sync_b, busy_b, pd_done_b};
        for (int k = 0; k < 2; k++) begin
            if (q_exp[k].size() > 0) begin
                e = q_exp[k].pop_front();
                total++;
                if (act[k] !== e) begin
                    bad++;
                    $display("FAIL outputs_%s t=%0t got=%b want=%b",
                             (k == 0) ? "step4" : "step0", $time, act[k], e);
                end
            end
        end
    end

    initial begin
        m_step[0] = 4;  m_fto[0] = 16;
        m_step[1] = 1;  m_fto[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_started[k] = 1'b0;
            m_t0[k] = 0;
            m_tled[k] = -1;
        end

        // Idle after reset: everything stays on.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(20);

        // Request then frame_end three cycles later.
        drive(1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b1);
        idle(24);

        // No frame_end: timeout path, with pd_req held high throughout.
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'b0);

        // Reset at the edge disp_en would fall, then restart.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b1);
        idle(3);
        drive(1'b1, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, 1'b1, 1'b0);
        idle(6);
        drive(1'b0, 1'b0, 1'b1);
        idle(24);

        // frame_end coincident with the request is ignored; next pulse at t0+5.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        idle(4);
        drive(1'b0, 1'b0, 1'b1);
        idle(20);

        // Reset out of DONE.
        drive(1'b1, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 299) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0);
        end
        idle(2);
        @(negedge clk_out);

        total++;
        if ((q_exp[0].size() + q_exp[1].size()) != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", q_exp[0].size() + q_exp[1].size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
